// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: program-load, control and CPU instruction-issue signals of the sequencer.
interface instr_sequencer_if #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
);
    logic                   prog_we;
    logic [PC_BITS-1:0]     prog_addr;
    logic [INSTR_WIDTH-1:0] prog_data;
    logic                   start;
    logic [PC_BITS-1:0]     start_addr;
    logic                   halt_req;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [PC_BITS-1:0]     pc;
    logic                   issue;
    logic                   busy;
    logic                   done;
    modport master (
        input  prog_we, prog_addr, prog_data, start, start_addr, halt_req,
        output instruction, pc, issue, busy, done
    );
    modport slave (
        output prog_we, prog_addr, prog_data, start, start_addr, halt_req,
        input  instruction, pc, issue, busy, done
    );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches words from a small program memory and holds each one
// on the CPU instruction bus for a class-dependent number of cycles.
module instr_sequencer #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5,
    parameter int CYC_ALU     = 3,
    parameter int CYC_MEM     = 4
) (
    input logic clk,
    input logic rst,
    instr_sequencer_if.master bus
);
    localparam int DEPTH = 2 ** PC_BITS;
    localparam int CMAX  = CYC_ALU > CYC_MEM ? CYC_ALU : CYC_MEM;
    localparam int CW    = $clog2(CMAX + 1);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;
    state_t                 state, state_n;
    logic [PC_BITS-1:0]     pc_q, pc_n;
    logic [INSTR_WIDTH-1:0] instr_q, instr_n, rdata;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   issue_q, issue_n, hflag, hflag_n, busy, wr_en;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    assign busy  = state == FETCH || state == ISSUE;
    assign wr_en = bus.prog_we && !busy;
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        instr_n = instr_q;
        cnt_n   = cnt;
        issue_n = 1'b0;
        hflag_n = busy && (hflag || bus.halt_req);
        case (state)
            IDLE, DONE: begin
                instr_n = '0;
                if (bus.start) begin
                    pc_n    = bus.start_addr;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                // class 2'b00 is HALT: stop without presenting the word
                if (rdata[INSTR_WIDTH-1 -: 2] == 2'b00) begin
                    state_n = DONE;
                end else begin
                    instr_n = rdata;
                    issue_n = 1'b1;
                    cnt_n   = rdata[INSTR_WIDTH-1] ? CW'(CYC_MEM - 1) : CW'(CYC_ALU - 1);
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (hflag || bus.halt_req || pc_q == PC_BITS'(DEPTH - 1)) begin
                    state_n = DONE;
                end else begin
                    pc_n    = pc_q + PC_BITS'(1);
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            cnt     <= '0;
            issue_q <= 1'b0;
            hflag   <= 1'b0;
        end else begin
            state   <= state_n;
            pc_q    <= pc_n;
            instr_q <= instr_n;
            cnt     <= cnt_n;
            issue_q <= issue_n;
            hflag   <= hflag_n;
        end
    end
    // read address is the next pc so the word is ready in FETCH; a same-cycle write wins
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[bus.prog_addr] <= bus.prog_data;
        rdata <= (wr_en && bus.prog_addr == pc_n) ? bus.prog_data : mem[pc_n];
    end
    assign bus.instruction = instr_q;
    assign bus.pc          = pc_q;
    assign bus.issue       = issue_q;
    assign bus.busy        = busy;
    assign bus.done        = state == DONE;
endmodule
